// File: rtl/inst_queue.sv
// inst_queue: circular instruction/PC FIFO between fetch and decoder
module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4,
    parameter int ID_W   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_instqueue_en_in,
    input  logic [ID_W-1:0]   if_instqueue_inst_in,
    input  logic [ADDR_W-1:0] if_instqueue_pc_in,
    output logic              instqueue_if_rdy_out,
    output logic              instqueue_decoder_en_out,
    output logic [ID_W-1:0]   instqueue_decoder_inst_out,
    output logic [ADDR_W-1:0] instqueue_decoder_pc_out,
    input  logic              decoder_instqueue_rdy_in,
    input  logic              decoder_instqueue_clear_in,
    input  logic              rob_instqueue_clear_in
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [ID_W-1:0]   inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [PTR_W:0]    count;
    logic              clear, push, pop;

    assign clear = rob_instqueue_clear_in | decoder_instqueue_clear_in;
    assign push  = if_instqueue_en_in && count < FULL;
    assign pop   = decoder_instqueue_rdy_in && count != '0;
    // Reserve room for the push fetch already has in flight; pops are ignored.
    assign instqueue_if_rdy_out = !rst_in && (count + (PTR_W+1)'(if_instqueue_en_in)) < FULL;

    // Entry storage: written at tail, never cleared
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !clear && push) begin
            inst_mem[tail] <= if_instqueue_inst_in;
            pc_mem[tail]   <= if_instqueue_pc_in;
        end
    end

    // Pointers, occupancy and the registered output pair
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head                       <= '0;
            tail                       <= '0;
            count                      <= '0;
            instqueue_decoder_en_out   <= 1'b0;
            instqueue_decoder_inst_out <= '0;
            instqueue_decoder_pc_out   <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                head                     <= '0;
                tail                     <= '0;
                count                    <= '0;
                instqueue_decoder_en_out <= 1'b0;
            end else begin
                tail                     <= tail + PTR_W'(push);
                head                     <= head + PTR_W'(pop);
                count                    <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
                instqueue_decoder_en_out <= pop;
                if (pop) begin
                    instqueue_decoder_inst_out <= inst_mem[head];
                    instqueue_decoder_pc_out   <= pc_mem[head];
                end
            end
        end
    end

    overflow_check: assert property (@(posedge clk_in) disable iff (rst_in)
        !(rdy_in && !clear && if_instqueue_en_in && count == FULL));
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: randomized scoreboard bench for inst_queue against a queue-based model
module tb_inst_queue;
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic        clk_in = 0, rst_in = 1, rdy_in = 1;
    logic        if_en = 0;
    logic [31:0] if_inst = 0, if_pc = 0;
    logic        rdy_out, en_out;
    logic [31:0] inst_out, pc_out;
    logic        dec_rdy = 0, dec_clr = 0, rob_clr = 0;

    inst_queue dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_instqueue_en_in(if_en), .if_instqueue_inst_in(if_inst), .if_instqueue_pc_in(if_pc),
        .instqueue_if_rdy_out(rdy_out),
        .instqueue_decoder_en_out(en_out), .instqueue_decoder_inst_out(inst_out),
        .instqueue_decoder_pc_out(pc_out),
        .decoder_instqueue_rdy_in(dec_rdy), .decoder_instqueue_clear_in(dec_clr),
        .rob_instqueue_clear_in(rob_clr)
    );

    always #5 clk_in = ~clk_in;

    ent_t        q[$];
    ent_t        sb[$];
    int          nvec = 0, nerr = 0;
    logic        pend = 0;
    logic [31:0] pend_inst = 0, pend_pc = 0;
    logic [31:0] next_pc = 0;
    logic        rand_inst = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One bench cycle: drive at negedge, check ready, advance the model for the coming edge
    task automatic cyc(input logic w, input logic dr, input logic rc, input logic dc,
                       input logic r, input logic rs);
        int   n;
        logic p;
        ent_t e;
        @(negedge clk_in);
        rst_in = rs; rdy_in = r; dec_rdy = dr; rob_clr = rc; dec_clr = dc;
        if_en = pend; if_inst = pend_inst; if_pc = pend_pc;
        #1;
        chk("rdy_out", {31'b0, rdy_out}, {31'b0, !rs && (q.size() + int'(if_en)) < 16});
        if (rs) pend = 0;
        else if (r) begin
            pend = w && rdy_out;
            if (pend) begin
                pend_pc   = next_pc;
                pend_inst = rand_inst ? $urandom : 32'h00000013;
                next_pc  += 4;
            end
        end
        if (rs) q.delete();
        else if (r) begin
            if (rc || dc) q.delete();
            else begin
                n = q.size();
                p = if_en && n < 16;
                if (dr && n > 0) sb.push_back(q.pop_front());
                if (p) begin
                    e.inst = if_inst;
                    e.pc   = if_pc;
                    q.push_back(e);
                end
            end
        end
    endtask

    // Monitor: compares each DUT output strobe against the scoreboard
    logic act_e, rst_e, prev_en;
    always @(posedge clk_in) begin
        ent_t e;
        act_e   = rdy_in & ~rst_in;
        rst_e   = rst_in;
        prev_en = en_out;
        #1;
        if (rst_e) begin
            chk("reset en_out", {31'b0, en_out}, 32'd0);
            chk("reset pc_out", pc_out, 32'd0);
            chk("reset inst_out", inst_out, 32'd0);
        end else if (!act_e) chk("hold en_out", {31'b0, en_out}, {31'b0, prev_en});
        else if (en_out) begin
            if (sb.size() == 0) chk("unexpected output pc", pc_out, 32'hxxxxxxxx);
            else begin
                e = sb.pop_front();
                chk("output pc", pc_out, e.pc);
                chk("output inst", inst_out, e.inst);
            end
        end else if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("missing output pc", 32'hxxxxxxxx, e.pc);
        end
    end

    initial begin
        repeat (2) cyc(0, 0, 0, 0, 1, 1);
        // three back-to-back pushes with the decoder ready
        next_pc = 32'h0;
        repeat (3) cyc(1, 1, 0, 0, 1, 0);
        repeat (5) cyc(0, 1, 0, 0, 1, 0);
        rand_inst = 1;
        // fill to capacity with decoder stalled, then drain
        next_pc = 32'h100;
        repeat (25) cyc(1, 0, 0, 0, 1, 0);
        repeat (20) cyc(0, 1, 0, 0, 1, 0);
        // pointer wrap
        next_pc = 32'h1000;
        repeat (11) cyc(1, 0, 0, 0, 1, 0);
        repeat (12) cyc(0, 1, 0, 0, 1, 0);
        repeat (20) cyc(1, 1, 0, 0, 1, 0);
        repeat (4) cyc(0, 1, 0, 0, 1, 0);
        // ROB clear with a push in flight, then a fresh push
        next_pc = 32'h2000;
        repeat (6) cyc(1, 0, 0, 0, 1, 0);
        next_pc = 32'h200;
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0);
        next_pc = 32'h400;
        cyc(1, 0, 0, 0, 1, 0);
        repeat (4) cyc(0, 1, 0, 0, 1, 0);
        // both clears together
        next_pc = 32'h3000;
        repeat (4) cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 1, 1, 0);
        repeat (3) cyc(0, 1, 0, 0, 1, 0);
        // global stall mid-stream, then reset mid-stream
        next_pc = 32'h4000;
        repeat (6) cyc(1, 1, 0, 0, 1, 0);
        repeat (4) cyc(1, 1, 0, 0, 0, 0);
        repeat (6) cyc(1, 1, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 1, 1);
        repeat (4) cyc(1, 1, 0, 0, 1, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 60) == 0, $urandom_range(0, 60) == 0,
                $urandom_range(0, 15) != 0, $urandom_range(0, 150) == 0);
        repeat (25) cyc(0, 1, 0, 0, 1, 0);
        chk("final model empty", q.size(), 32'd0);
        @(negedge clk_in);
        chk("final scoreboard empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Circular FIFO between the fetch stage and the decoder.
- Accepts one fetched instruction/PC pair per cycle from fetch. Presents one registered instruction/PC pair per cycle to the decoder.
- Flushed on a ROB mispredict redirect or a decoder jump redirect.
- Back-pressures fetch with a ready that accounts for fetch's one-cycle registered push latency.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4
PTR_W, 4, log2(DEPTH); pointer width (count register is PTR_W+1 bits)

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; when low, all state and outputs hold
if_instqueue_en_in  input  1  push strobe from fetch, valid for this cycle only
if_instqueue_inst_in  input  `IDWidth (32)  instruction word to push
if_instqueue_pc_in  input  `AddressWidth (32)  PC of pushed instruction
instqueue_if_rdy_out  output  1  fetch may issue a push decision this cycle (combinational)
instqueue_decoder_en_out  output  1  registered; output pair valid this cycle
instqueue_decoder_inst_out  output  `IDWidth  registered instruction to decoder
instqueue_decoder_pc_out  output  `AddressWidth  registered PC to decoder
decoder_instqueue_rdy_in  input  1  decoder can accept an instruction at the next edge
decoder_instqueue_clear_in  input  1  decoder jump redirect; flush
rob_instqueue_clear_in  input  1  ROB mispredict redirect; flush (priority over decoder clear)

Behaviour:
- State: entry arrays inst[DEPTH] and pc[DEPTH]; head and tail (PTR_W bits, wrap naturally mod DEPTH); count (PTR_W+1 bits, range 0..DEPTH).
- Reset (rst_in=1 at edge): head=tail=count=0; instqueue_decoder_en_out=0; inst_out and pc_out = 0. Entry arrays are not cleared. Reset overrides rdy_in and all other inputs.
- rdy_in=0 with rst_in=0: nothing changes; en_out keeps its value.
- Priority per edge (rdy_in=1): rob clear > decoder clear > normal operation.
- Clear (either clear input high):
  - head=tail=count=0; en_out=0.
  - A push presented in the same cycle is discarded, because it is stale fetch data.
  - The current output pair is dropped.
- Normal operation, evaluated per edge:
  - push = if_instqueue_en_in && count < DEPTH: write inst/pc at tail; tail = tail+1.
  - pop = decoder_instqueue_rdy_in && count > 0:
    - en_out = 1; inst_out/pc_out = entry[head]; head = head+1.
  - No pop: en_out = 0. inst_out/pc_out hold their last value (don't-care).
  - count = count + push - pop. Push and pop in the same edge are both performed; count is unchanged.
  - A push into an empty queue is not bypassed. The entry is written at edge N, is poppable at edge N+1, and en_out is high in the cycle after edge N+1.
- Ready rule (combinational): instqueue_if_rdy_out = (count + if_instqueue_en_in) < DEPTH.
  - Rationale: fetch registers its push one edge after sampling ready. The push in flight this cycle must be reserved.
  - Pops are ignored, so the rule is conservative.
  - instqueue_if_rdy_out is forced 0 while rst_in=1.
- Overflow: if_instqueue_en_in with count==DEPTH is a protocol violation. The push is dropped, no state is corrupted, and a simulation-only assertion fires.
- FIFO order is strictly preserved across pointer wrap-around.
- en_out is a one-cycle strobe per instruction. The decoder must consume it in the cycle it is high; there is no hold/retry on the output side.

Test Plan:
- Reset, then push PCs 0x0,0x4,0x8 (inst 0x00000013) on consecutive cycles, decoder rdy=1 throughout -> en_out high for 3 consecutive cycles, starting 2 edges after the first push edge, with pc_out 0x0,0x4,0x8 in order; count returns to 0.
- Decoder rdy=0, fetch pushes whenever rdy_out=1 with PCs 0x100+4k -> rdy_out drops when count=15 with push active (or count=16); exactly 16 entries are stored and no overflow assertion fires. Then decoder rdy=1 -> 16 pops, PCs 0x100..0x13C in order.
- Fill 10 entries, pop 10, push/pop 20 more (pointer wrap) -> output PC sequence matches push sequence exactly; count never exceeds 16.
- Queue holding 5 entries, assert rob_instqueue_clear_in together with a push of PC 0x200 -> next cycle count=0, en_out=0, rdy_out=1; a subsequent push of PC 0x400 is the next instruction output.
- Queue holding 3 entries, decoder_instqueue_clear_in and rob_instqueue_clear_in high in the same cycle -> flushed identically; no stale entry ever appears on en_out.
- rdy_in=0 for 4 cycles mid-stream with pushes/pops requested -> no state change, en_out holds; streaming resumes without loss when rdy_in=1. rst_in mid-stream -> all outputs 0 at the next cycle and queue empty.
